// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types and constants for the bit-serial subtractor.
//   - state_t      : control FSM states (IDLE -> RUN -> DONE -> IDLE)
//   - DEFAULT_WIDTH: default operand width
//   - cnt_width()  : bit-counter width for a given operand width ($clog2)
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only has to reach width-1, so $clog2(width) bits suffice.
    // The guard keeps the width at least one bit for degenerate inputs.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   One-bit full subtractor cell: computes ai - bi - bin.
//   Ports:
//     ai   in  minuend bit
//     bi   in  subtrahend bit
//     bin  in  borrow in
//     d    out difference bit
//     bout out borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor. Accepts a and b on a valid/ready
//   handshake, computes a - b one bit per cycle LSB first through a single
//   full_subtractor cell, and presents the difference and the final borrow
//   on an output valid/ready handshake. One operation in flight at a time;
//   acceptance at edge k gives out_valid after edge k+WIDTH.
//
//   Optional build macro SERIAL_SUB_SAT_EN: when defined, a result with a
//   final borrow reads as all-zeros (unsigned floor saturation); borrow_out
//   still reports 1. Undefined: diff is a - b mod 2^WIDTH.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   synchronous active-low reset
//     in_valid   in   operands valid
//     in_ready   out  block can accept operands (IDLE)
//     a, b       in   minuend / subtrahend, WIDTH bits
//     out_valid  out  diff/borrow_out valid (DONE)
//     out_ready  in   consumer accepts result
//     diff       out  difference, WIDTH bits
//     borrow_out out  1 when a < b
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int                 CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   ONE   = CNT_W'(1);

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CNT_W-1:0] count;

    logic             d;
    logic             bout;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] res_final;
    logic             last_bit;

    // Single cell, reused every RUN cycle on the operand LSBs.
    full_subtractor u_cell (
        .ai   (a_sr[0]),
        .bi   (b_sr[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    assign last_bit  = (count == LAST);
    assign res_shift = {d, res_sr[WIDTH-1:1]};

`ifdef SERIAL_SUB_SAT_EN
    // Clamp is applied once, on the edge that produces the last bit, so the
    // DONE value is already registered.
    assign res_final = bout ? '0 : res_shift;
`else
    assign res_final = res_shift;
`endif

    // Outputs come straight from registers; handshake flags decode state only.
    assign diff       = res_sr;
    assign borrow_out = borrow;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, result shifter, borrow and bit counter.
    always_ff @(posedge clk) begin
        // NOTE: the datapath is reset too, because diff and borrow_out are
        // read directly from these registers and must read zero after reset.
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        borrow <= 1'b0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= bout;
                    count  <= count + ONE;
                    res_sr <= last_bit ? res_final : res_shift;
                end
                default: begin
                    // DONE holds the result until it is taken.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). Expected results
//   come from plain integer subtraction; honours SERIAL_SUB_SAT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int TIMEOUT = 50;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    // Reference: integer subtraction, borrow is the sign of the true result.
    function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  output logic [WIDTH-1:0] d, output logic bo);
        int r;
        r  = int'(x) - int'(y);
        bo = (r < 0);
        d  = WIDTH'(r);
`ifdef SERIAL_SUB_SAT_EN
        if (bo) d = '0;
`endif
    endfunction

    // Presents one operand pair and waits for out_valid.
    // lat = edges from acceptance to out_valid, 0 on timeout or no acceptance.
    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ordy, output int lat);
        logic accepted;
        lat = 0;
        @(negedge clk);
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = ordy;
        accepted  = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        if (accepted) begin
            for (int n = 1; n <= TIMEOUT; n++) begin
                @(posedge clk);
                @(negedge clk);
                if (out_valid) begin
                    lat = n;
                    break;
                end
            end
        end
    endtask

    // Takes the pending result and lands at a negedge back in IDLE.
    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit seen;
        apply_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h borrow=%b, required 1 0 00 0",
                     in_ready, out_valid, diff, borrow_out);
        end

        // Reset mid-RUN discards the operation.
        @(negedge clk);
        a = 8'h55; b = 8'h11; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: in_ready=%b out_valid=%b diff=%h borrow=%b, required 1 0 00 0",
                     in_ready, out_valid, diff, borrow_out);
        end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_no_result: out_valid or in_ready changed after discard, required idle");
        end
    endtask

    // Single operation with latency and value checks.
    task automatic check_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int lat;
        logic [WIDTH-1:0] exp_d;
        logic exp_b;
        model(x, y, exp_d, exp_b);
        do_op(x, y, 1'b1, lat);
        n_checks++;
        if (lat != WIDTH) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, WIDTH);
        end
        n_checks++;
        if (diff !== exp_d || borrow_out !== exp_b) begin
            n_fail++;
            $display("FAIL %s_result: a=%h b=%h diff=%h borrow=%b, required diff=%h borrow=%b",
                     name, x, y, diff, borrow_out, exp_d, exp_b);
        end
        take_result();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_return_idle: in_ready=%b out_valid=%b, required 1 0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        check_op("basic", 8'd200, 8'd55);
    endtask

    task automatic test_underflow();
        check_op("underflow", 8'd3, 8'd5);
    endtask

    task automatic test_extremes();
        check_op("zero_minus_max", 8'h00, 8'hFF);
        check_op("max_minus_max", 8'hFF, 8'hFF);
        check_op("equal_mid", 8'h5A, 8'h5A);
    endtask

    task automatic test_backpressure();
        int lat;
        bit bad;
        logic [WIDTH-1:0] exp_d;
        logic exp_b;
        model(8'h10, 8'h20, exp_d, exp_b);
        do_op(8'h10, 8'h20, 1'b0, lat);
        n_checks++;
        if (lat != WIDTH || diff !== exp_d || borrow_out !== exp_b) begin
            n_fail++;
            $display("FAIL bp_result: lat=%0d diff=%h borrow=%b, required lat=%0d diff=%h borrow=%b",
                     lat, diff, borrow_out, WIDTH, exp_d, exp_b);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== exp_d || borrow_out !== exp_b)
                bad = 1'b1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: out_valid=%b in_ready=%b diff=%h borrow=%b, required 1 0 %h %b",
                     out_valid, in_ready, diff, borrow_out, exp_d, exp_b);
        end
        take_result();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        // If in_valid had been taken during DONE the block would now be busy.
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_accept: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 1000;
        logic [2*WIDTH-1:0] q[$];
        logic [2*WIDTH-1:0] ent;
        logic [WIDTH-1:0] exp_d;
        logic exp_b;
        int pushed = 0;
        int results = 0;
        int last_acc = -1;
        int bad_val = 0;
        int bad_period = 0;
        bit done = 1'b0;

        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        for (int cyc = 0; cyc < N * (WIDTH + 2) + 200; cyc++) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    bad_val++;
                end else begin
                    ent = q.pop_front();
                    model(ent[2*WIDTH-1:WIDTH], ent[WIDTH-1:0], exp_d, exp_b);
                    if (diff !== exp_d || borrow_out !== exp_b) begin
                        bad_val++;
                        if (bad_val <= 5)
                            $display("FAIL b2b_result: a=%h b=%h diff=%h borrow=%b, required diff=%h borrow=%b",
                                     ent[2*WIDTH-1:WIDTH], ent[WIDTH-1:0], diff, borrow_out, exp_d, exp_b);
                    end
                end
                results++;
            end
            if (in_ready && in_valid) begin
                q.push_back({a, b});
                pushed++;
                if (last_acc >= 0 && cyc - last_acc != WIDTH + 2) bad_period++;
                last_acc = cyc;
            end else begin
                // Operands move freely while busy; only the acceptance edge counts.
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                if (pushed >= N) in_valid = 1'b0;
            end
            if (results >= N) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (!done || bad_val != 0) begin
            n_fail++;
            $display("FAIL b2b_stream: %0d results, %0d wrong, required %0d results 0 wrong",
                     results, bad_val, N);
        end
        n_checks++;
        if (bad_period != 0) begin
            n_fail++;
            $display("FAIL b2b_period: %0d acceptance intervals off, required every %0d cycles",
                     bad_period, WIDTH + 2);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_basic();
        test_underflow();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
